// File: rtl/proc_pkg.sv
// Shared definitions for the 20-bit pipelined processor.
// Holds opcode constants, datapath widths and the opcode-field helper.
package proc_pkg;

   localparam int unsigned DATA_W  = 20;
   localparam int unsigned REG_W   = 4;
   localparam int unsigned OPC_W   = 4;
   localparam int unsigned OPC_MSB = 19;
   localparam int unsigned OPC_LSB = 16;

   localparam logic [OPC_W-1:0] OP_LD  = 4'h8;
   localparam logic [OPC_W-1:0] OP_ST  = 4'h9;
   localparam logic [OPC_W-1:0] OP_BEQ = 4'hA;
   localparam logic [OPC_W-1:0] OP_JMP = 4'hB;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } mem_state_e;

   // Operands captured when a load/store is accepted.
   typedef struct packed {
      logic              is_ld;
      logic [DATA_W-1:0] result;
      logic [REG_W-1:0]  dest;
      logic [DATA_W-1:0] instr;
   } mem_op_t;

   function automatic logic [OPC_W-1:0] opcode_of(input logic [DATA_W-1:0] instr);
      return instr[OPC_MSB:OPC_LSB];
   endfunction

endpackage

// File: rtl/mem_handshake_fsm.sv
// IDLE/ACCESS sequencer for the data-memory req/ack handshake.
// Owns the timeout counter and the registered request line.
module mem_handshake_fsm
   import proc_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clock,
   input  logic reset,
   input  logic start_i,
   input  logic ack_i,
   output logic access_o,
   output logic req_o,
   output logic done_o,
   output logic timeout_hit_o
);

   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   mem_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             req_q;

   assign access_o      = (state_q == ST_ACCESS);
   assign req_o         = req_q;
   assign done_o        = access_o & ack_i;
   // Counter reads TIMEOUT-1 in the TIMEOUT-th request cycle.
   assign timeout_hit_o = access_o & ~ack_i & (cnt_q == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         req_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  state_q <= ST_ACCESS;
                  cnt_q   <= '0;
                  req_q   <= 1'b1;
               end
            end
            ST_ACCESS: begin
               if (ack_i || timeout_hit_o) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
                  req_q   <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/mem_stage_access.sv
// MEM stage: issues loads/stores over req/ack, stalls upstream while busy,
// and registers the MEM/WB outputs toward write-back.
module mem_stage_access
   import proc_pkg::*;
#(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] instruction,
   input  logic [DATA_W-1:0] aluRESULT,
   input  logic [DATA_W-1:0] storeData,
   input  logic [REG_W-1:0]  opDestino,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall,
   output logic              wb_valid,
   output logic              wb_we,
   output logic [REG_W-1:0]  wb_reg,
   output logic [DATA_W-1:0] wb_data,
   output logic [DATA_W-1:0] wb_instruction,
   output logic              err
);

   logic [OPC_W-1:0] opc;
   logic             is_ld, is_st, is_mem, is_alu;
   logic             access, accept, done, timeout_hit;
   mem_op_t          op_q;

   assign opc    = opcode_of(instruction);
   assign is_ld  = (opc == OP_LD);
   assign is_st  = (opc == OP_ST);
   assign is_mem = is_ld | is_st;
   assign is_alu = ~(is_mem | (opc == OP_BEQ) | (opc == OP_JMP));
   assign accept = ~access & in_valid & is_mem;

   assign stall = accept | (access & ~mem_ack & ~timeout_hit);

   mem_handshake_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
      .clock         (clock),
      .reset         (reset),
      .start_i       (accept),
      .ack_i         (mem_ack),
      .access_o      (access),
      .req_o         (mem_req),
      .done_o        (done),
      .timeout_hit_o (timeout_hit)
   );

   // Memory-side operand latches, held stable for the whole access.
   always_ff @(posedge clock) begin
      if (reset) begin
         op_q      <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (accept) begin
         op_q.is_ld  <= is_ld;
         op_q.result <= aluRESULT;
         op_q.dest   <= opDestino;
         op_q.instr  <= instruction;
         mem_we      <= is_st;
         mem_addr    <= aluRESULT[ADDR_W-1:0];
         mem_wdata   <= storeData;
      end
   end

   // MEM/WB register: one retirement pulse per instruction.
   always_ff @(posedge clock) begin
      if (reset) begin
         wb_valid       <= 1'b0;
         wb_we          <= 1'b0;
         wb_reg         <= '0;
         wb_data        <= '0;
         wb_instruction <= '0;
         err            <= 1'b0;
      end else begin
         wb_valid <= 1'b0;
         wb_we    <= 1'b0;
         if (~access && in_valid && ~is_mem) begin
            wb_valid       <= 1'b1;
            wb_we          <= is_alu;
            wb_reg         <= opDestino;
            wb_data        <= aluRESULT;
            wb_instruction <= instruction;
         end else if (done) begin
            wb_valid       <= 1'b1;
            wb_we          <= op_q.is_ld;
            wb_reg         <= op_q.dest;
            wb_data        <= op_q.is_ld ? mem_rdata : op_q.result;
            wb_instruction <= op_q.instr;
         end else if (timeout_hit) begin
            wb_valid       <= 1'b1;
            wb_reg         <= op_q.dest;
            wb_instruction <= op_q.instr;
            err            <= 1'b1;
         end
      end
   end

endmodule
